// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and types for the multiplexed 7-segment scanner.
// Segment codes are active-low and ordered {dp,g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int NIB_W = 4;

    typedef logic [NIB_W-1:0] nibble_t;
    typedef logic [7:0]       segcode_t;

    localparam segcode_t SEG_OFF = 8'hFF;

    localparam segcode_t SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Bus-side bundle of the scanner: display data/control in, pin drives out.
interface seg7_scan_ctrl_if
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 8
);
    logic [NIB_W*N_DIGITS-1:0] i_data;
    logic [N_DIGITS-1:0]       i_dp;
    logic [N_DIGITS-1:0]       i_blank;
    logic [N_DIGITS-1:0]       i_blink;
    logic                      i_lz_en;
    logic [3:0]                i_bright;
    logic                      i_load;
    logic [7:0]                o_seg;
    logic [N_DIGITS-1:0]       o_sel;
    logic                      o_frame;

    modport master (
        output i_data, i_dp, i_blank, i_blink, i_lz_en, i_bright, i_load,
        input  o_seg, o_sel, o_frame
    );

    modport slave (
        input  i_data, i_dp, i_blank, i_blink, i_lz_en, i_bright, i_load,
        output o_seg, o_sel, o_frame
    );

endinterface

// File: rtl/seg7_scan_ctrl_decode.sv
// Nibble to active-low segment code, with decimal point and forced-dark override.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  nibble_t  nibble_i,
    input  logic     dp_i,
    input  logic     dark_i,
    output segcode_t seg_o
);

    always_comb begin
        seg_o = SEG_TABLE[nibble_i];
        if (dp_i) begin
            seg_o[7] = 1'b0;
        end
        if (dark_i) begin
            seg_o = SEG_OFF;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner: frame-synchronous shadow loading, blink,
// leading-zero suppression and 16-level brightness gating of the digit select.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int DIV_W      = 15,
    parameter int BLINK_LOG2 = 6,
    parameter bit ACTIVE_LOW = 1'b1
)(
    input  logic              clk,
    input  logic              rstn,
    seg7_scan_ctrl_if.slave   bus
);

    localparam int IDX_W  = $clog2(N_DIGITS);
    localparam int DATA_W = NIB_W * N_DIGITS;

    localparam logic [7:0]          SEG_IDLE = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] SEL_IDLE = ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic [DIV_W-1:0]      prescale_q;
    logic [IDX_W-1:0]      idx_q;
    logic [BLINK_LOG2:0]   blink_q;
    logic                  frame_q;
    logic [7:0]            seg_q;
    logic [N_DIGITS-1:0]   sel_q;

    logic [DATA_W-1:0]     pendData_q, dispData_q;
    logic [N_DIGITS-1:0]   pendDp_q, pendBlank_q, pendBlink_q;
    logic [N_DIGITS-1:0]   dispDp_q, dispBlank_q, dispBlink_q;

    logic                  tick, frameEnd, brightOk, dark, lzRun;
    logic [N_DIGITS-1:0]   lzMask, selOneHot, selVec;
    nibble_t               curNib;
    segcode_t              decCode;

    assign tick      = &prescale_q;
    assign frameEnd  = tick && (idx_q == IDX_W'(N_DIGITS - 1));
    assign brightOk  = prescale_q[DIV_W-1 -: 4] <= bus.i_bright;
    assign selOneHot = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    assign selVec    = brightOk ? selOneHot : '0;
    assign curNib    = dispData_q[int'(idx_q) * NIB_W +: NIB_W];

    // A digit is suppressed while it and every more significant nibble are zero;
    // digit 0 is never in the mask so a zero value still shows one "0".
    always_comb begin
        lzRun  = bus.i_lz_en;
        lzMask = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            lzRun     = lzRun && (dispData_q[k*NIB_W +: NIB_W] == '0);
            lzMask[k] = lzRun;
        end
    end

    assign dark = dispBlank_q[idx_q]
                | (dispBlink_q[idx_q] & blink_q[BLINK_LOG2])
                | lzMask[idx_q];

    seg7_hex_decode uDecode (
        .nibble_i (curNib),
        .dp_i     (dispDp_q[idx_q]),
        .dark_i   (dark),
        .seg_o    (decCode)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prescale_q  <= '0;
            idx_q       <= '0;
            blink_q     <= '0;
            frame_q     <= 1'b0;
            seg_q       <= SEG_IDLE;
            sel_q       <= SEL_IDLE;
            pendData_q  <= '0;
            pendDp_q    <= '0;
            pendBlank_q <= '0;
            pendBlink_q <= '0;
            dispData_q  <= '0;
            dispDp_q    <= '0;
            dispBlank_q <= '0;
            dispBlink_q <= '0;
        end else begin
            prescale_q <= prescale_q + 1'b1;
            if (tick) begin
                idx_q <= frameEnd ? '0 : idx_q + IDX_W'(1);
            end
            frame_q <= frameEnd;
            if (bus.i_load) begin
                pendData_q  <= bus.i_data;
                pendDp_q    <= bus.i_dp;
                pendBlank_q <= bus.i_blank;
                pendBlink_q <= bus.i_blink;
            end
            // A load landing on the boundary bypasses the pending copy.
            if (frameEnd) begin
                blink_q     <= blink_q + 1'b1;
                dispData_q  <= bus.i_load ? bus.i_data  : pendData_q;
                dispDp_q    <= bus.i_load ? bus.i_dp    : pendDp_q;
                dispBlank_q <= bus.i_load ? bus.i_blank : pendBlank_q;
                dispBlink_q <= bus.i_load ? bus.i_blink : pendBlink_q;
            end
            seg_q <= ACTIVE_LOW ? decCode : ~decCode;
            sel_q <= ACTIVE_LOW ? ~selVec : selVec;
        end
    end

    assign bus.o_seg   = seg_q;
    assign bus.o_sel   = sel_q;
    assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (4 digits, 16-cycle slots, blink every 2 frames).
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int SLOT  = 16;
    localparam int FRAME = N * SLOT;

    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
    } content_t;

    typedef struct packed {
        logic       frame;
        logic [3:0] sel;
        logic [7:0] seg;
    } out_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    seg7_scan_ctrl_if #(.N_DIGITS(N)) bus ();

    seg7_scan_ctrl #(
        .N_DIGITS   (N),
        .DIV_W      (4),
        .BLINK_LOG2 (1),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int unsigned edgeCnt  = 0;
    content_t    pend, disp;
    out_t        expQ[$];
    out_t        monExp;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected pins for scan position p (cycles since reset release), worked out
    // from slot/frame arithmetic rather than from counters.
    function automatic out_t refOut(int unsigned p, content_t d, logic lz, logic [3:0] br);
        out_t       o;
        int         dig;
        logic       dark;
        logic [7:0] code;
        dig  = (p / SLOT) % N;
        dark = d.blank[dig]
            || (d.blink[dig] && (((p / FRAME) / 2) % 2 == 1))
            || (lz && dig != 0 && (d.data >> (4 * dig)) == 16'h0);
        code = HEX_SEG[d.data[dig*4 +: 4]];
        if (d.dp[dig]) code = code & 8'h7F;
        o.seg   = dark ? 8'hFF : code;
        o.sel   = ((p % SLOT) <= br) ? ~(4'b0001 << dig) : 4'hF;
        o.frame = ((p + 1) % FRAME == 0);
        return o;
    endfunction

    // Reference model: one expected output word per clock, content switches at frame edges.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            edgeCnt = 0;
            pend    = '0;
            disp    = '0;
            expQ.delete();
        end else begin
            edgeCnt = edgeCnt + 1;
            expQ.push_back(refOut(edgeCnt - 1, disp, bus.i_lz_en, bus.i_bright));
            if (bus.i_load) begin
                pend = '{data: bus.i_data, dp: bus.i_dp, blank: bus.i_blank, blink: bus.i_blink};
            end
            if (edgeCnt % FRAME == 0) disp = pend;
        end
    end

    // Monitor: compares the registered pins against the queued expectation.
    always @(negedge clk) begin
        if (rstn && expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput("scan", 32'({bus.o_frame, bus.o_sel, bus.o_seg}), 32'(monExp));
        end
    end

    task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dp,
                                 input logic [3:0] blank, input logic [3:0] blink);
        @(negedge clk);
        bus.i_data  = data;
        bus.i_dp    = dp;
        bus.i_blank = blank;
        bus.i_blink = blink;
        bus.i_load  = 1'b1;
        @(negedge clk);
        bus.i_load  = 1'b0;
    endtask

    task automatic loadAtBoundary(input logic [15:0] data, input logic [3:0] dp,
                                  input logic [3:0] blank, input logic [3:0] blink);
        int g = 0;
        @(negedge clk);
        while ((edgeCnt % FRAME) != FRAME - 1 && g < 4 * FRAME) begin
            @(negedge clk);
            g++;
        end
        checkOutput("boundary_wait", 32'(g < 4 * FRAME), 32'd1);
        bus.i_data  = data;
        bus.i_dp    = dp;
        bus.i_blank = blank;
        bus.i_blink = blink;
        bus.i_load  = 1'b1;
        @(negedge clk);
        bus.i_load  = 1'b0;
    endtask

    task automatic waitFrames(input int k);
        repeat (k * FRAME) @(negedge clk);
    endtask

    task automatic measureFirstFrame();
        int cnt = 0;
        while (cnt < 4 * FRAME) begin
            @(posedge clk);
            cnt++;
            #1;
            if (bus.o_frame) break;
        end
        checkOutput("first_frame_cycle", 32'(cnt), 32'(FRAME));
    endtask

    task automatic checkResetPins(input string tag);
        checkOutput({tag, "_seg"},   32'(bus.o_seg),   32'h0000_00FF);
        checkOutput({tag, "_sel"},   32'(bus.o_sel),   32'h0000_000F);
        checkOutput({tag, "_frame"}, 32'(bus.o_frame), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.i_data   = '0;
        bus.i_dp     = '0;
        bus.i_blank  = '0;
        bus.i_blink  = '0;
        bus.i_lz_en  = 1'b0;
        bus.i_bright = 4'd15;
        bus.i_load   = 1'b0;

        repeat (3) @(negedge clk);
        #1 checkResetPins("reset");
        rstn = 1'b1;
        measureFirstFrame();

        // Plain hex display, then a mid-frame reload and a boundary-coincident load
        applyStimulus(16'h1234, 4'h0, 4'h0, 4'h0);
        waitFrames(2);
        repeat (20) @(negedge clk);
        applyStimulus(16'hAAAA, 4'h0, 4'h0, 4'h0);
        waitFrames(2);
        loadAtBoundary(16'h5678, 4'b0100, 4'h0, 4'h0);
        waitFrames(1);

        // Leading-zero suppression
        bus.i_lz_en = 1'b1;
        applyStimulus(16'h0012, 4'h0, 4'h0, 4'h0);
        waitFrames(2);
        applyStimulus(16'h0000, 4'h0, 4'h0, 4'h0);
        waitFrames(2);
        applyStimulus(16'h0000, 4'b1000, 4'h0, 4'h0);
        waitFrames(2);
        bus.i_lz_en = 1'b0;

        // Brightness gating
        bus.i_bright = 4'd0;
        waitFrames(2);
        bus.i_bright = 4'd7;
        waitFrames(2);
        bus.i_bright = 4'd15;

        // Blink with decimal point and blanking
        applyStimulus(16'h0005, 4'b0001, 4'h0, 4'b0001);
        waitFrames(9);
        applyStimulus(16'h9F3C, 4'b1010, 4'b0100, 4'b0000);
        waitFrames(2);

        // Randomised loads, live controls and occasional boundary loads
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(1, 150)) @(negedge clk);
            bus.i_lz_en  = 1'($urandom);
            bus.i_bright = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                loadAtBoundary(16'($urandom_range(0, 255)), 4'($urandom), 4'($urandom_range(0, 1)), 4'($urandom));
            end else begin
                applyStimulus(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            end
        end
        waitFrames(2);

        // Asynchronous reset in the middle of a slot
        repeat ($urandom_range(5, 40)) @(negedge clk);
        #2 rstn = 1'b0;
        #1 checkResetPins("midreset");
        bus.i_load = 1'b0;
        repeat (3) @(negedge clk);
        #1 rstn = 1'b1;
        measureFirstFrame();
        waitFrames(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
